// File: rtl/systolic_skew_feeder_if.sv
// Operand-feeder bus: controller handshake, matrix snapshot inputs and skewed lane outputs.
interface systolic_skew_feeder_if #(
  parameter int N      = 3,
  parameter int K      = 3,
  parameter int DATA_W = 16
);
  logic                    start;
  logic [N*K*DATA_W-1:0]   a_flat;
  logic [K*N*DATA_W-1:0]   b_flat;
  logic [N*DATA_W-1:0]     row_out;
  logic [N*DATA_W-1:0]     col_out;
  logic [N-1:0]            lane_vld;
  logic                    busy;
  logic                    done;

  modport master (
    output start, a_flat, b_flat,
    input  row_out, col_out, lane_vld, busy, done
  );

  modport slave (
    input  start, a_flat, b_flat,
    output row_out, col_out, lane_vld, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for an N x N output-stationary systolic array (C = A*B).
// Optional drain phase enabled by defining SKEW_FEEDER_DRAIN_EN.
module systolic_skew_feeder #(
  parameter int N      = 3,
  parameter int K      = 3,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave fd
);
  localparam int CW = $clog2(K + 2*N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(K + N - 1);
`ifdef SKEW_FEEDER_DRAIN_EN
  localparam logic [CW-1:0] DRAIN_END = CW'(K + 2*N - 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED
`ifdef SKEW_FEEDER_DRAIN_EN
    , S_DRAIN
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q [N][K];
  logic [DATA_W-1:0]   b_q [K][N];
  logic [N*DATA_W-1:0] row_q, row_d;
  logic [N*DATA_W-1:0] col_q, col_d;
  logic [N-1:0]        vld_q, vld_d;
  logic                done_q, done_d;
  logic                snap_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (snap_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < K; k++) begin
          a_q[i][k] <= fd.a_flat[(i*K + k)*DATA_W +: DATA_W];
          b_q[k][i] <= fd.b_flat[(k*N + i)*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fd.start) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
`ifdef SKEW_FEEDER_DRAIN_EN
          state_d = (N > 1) ? S_DRAIN : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef SKEW_FEEDER_DRAIN_EN
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_END) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Step t feeds A[i][k]/B[k][i] on lane i exactly when t == i + k; all other lanes stay zero.
  always_comb begin
    row_d   = '0;
    col_d   = '0;
    vld_d   = '0;
    snap_en = (state_q == S_IDLE) && fd.start;
    done_d  = (state_q != S_IDLE) && (state_d == S_IDLE);
    if (state_q == S_FEED && cnt_q != LAST_STEP) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < K; k++) begin
          if (cnt_q == CW'(i + k)) begin
            row_d[i*DATA_W +: DATA_W] = a_q[i][k];
            col_d[i*DATA_W +: DATA_W] = b_q[k][i];
            vld_d[i]                  = 1'b1;
          end
        end
      end
    end
  end

  assign fd.row_out  = row_q;
  assign fd.col_out  = col_q;
  assign fd.lane_vld = vld_q;
  assign fd.done     = done_q;
  assign fd.busy     = (state_q != S_IDLE);

endmodule
